// File: rtl/coef_ram_loader.sv
// Byte-stream loader for the sin/cos2 coefficient RAM: parses SYNC/address/count/data/checksum
// frames, issues one RAM write per assembled word and reports frame status to the lookup side.
module coef_ram_loader #(
    parameter int         ADDR_W      = 11,
    parameter int         WORD_BYTES  = 6,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic                    Fg_CLK,
    input  logic                    RESET,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    table_valid
);

    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int BC_W   = $clog2(WORD_BYTES);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(WORD_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [12:0]      MAX_WORDS = 13'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_CNT_H,
        S_CNT_L,
        S_DATA,
        S_CHK
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          cnt_h_q;
    logic [11:0]         remain_q;
    logic [BC_W-1:0]     byte_cnt_q;
    logic [WORD_W-1:0]   asm_q;
    logic [7:0]          chk_q;
    logic [TMO_W-1:0]    tmo_q;

    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [WORD_W-1:0]   wr_data_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                table_valid_q;

    logic [WORD_W-1:0]   word_d;
    logic [11:0]         count_d;
    logic                count_ok;

    // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        word_d   = {asm_q[WORD_W-9:0], rx_data};
        count_d  = {cnt_h_q, rx_data};
        count_ok = (count_d != 12'd0) && ({1'b0, count_d} <= MAX_WORDS);
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Fg_CLK) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            cnt_h_q       <= '0;
            remain_q      <= '0;
            byte_cnt_q    <= '0;
            asm_q         <= '0;
            chk_q         <= '0;
            tmo_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            table_valid_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            // busy stays high through the cycle that carries the done/err pulse
            busy_q  <= 1'b1;

            if (state_q == S_IDLE) begin
                tmo_q  <= '0;
                busy_q <= 1'b0;
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    chk_q         <= '0;
                    table_valid_q <= 1'b0;
                    busy_q        <= 1'b1;
                    state_q       <= S_ADDR_H;
                end
            end else if (!rx_valid) begin
                if (tmo_q == TMO_LAST) begin
                    err_q   <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= S_IDLE;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
                if (state_q != S_CHK) begin
                    chk_q <= chk_q ^ rx_data;
                end

                case (state_q)
                    S_ADDR_H: begin
                        addr_q  <= ADDR_W'({rx_data, 8'h00});
                        state_q <= S_ADDR_L;
                    end
                    S_ADDR_L: begin
                        addr_q[7:0] <= rx_data;
                        state_q     <= S_CNT_H;
                    end
                    S_CNT_H: begin
                        cnt_h_q <= rx_data[3:0];
                        state_q <= S_CNT_L;
                    end
                    S_CNT_L: begin
                        if (count_ok) begin
                            remain_q   <= count_d;
                            byte_cnt_q <= '0;
                            state_q    <= S_DATA;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                    S_DATA: begin
                        asm_q <= word_d;
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_q <= '0;
                            wr_en_q    <= 1'b1;
                            wr_addr_q  <= addr_q;
                            wr_data_q  <= word_d;
                            addr_q     <= addr_q + 1'b1;
                            remain_q   <= remain_q - 12'd1;
                            if (remain_q == 12'd1) begin
                                state_q <= S_CHK;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                    S_CHK: begin
                        if (rx_data == chk_q) begin
                            done_q        <= 1'b1;
                            table_valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign table_valid = table_valid_q;

endmodule

// File: tb/tb_coef_ram_loader.sv
// Self-checking bench for coef_ram_loader: table-driven frames, hand-timed corner sequences
// and randomized frames compared against a frame-level model of the expected RAM writes.
module tb_coef_ram_loader;

    localparam int ADDR_W = 11;
    localparam int TMO    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [47:0] wr_data;
    logic        busy, done, err, table_valid;

    always #5 clk = ~clk;

    coef_ram_loader #(
        .ADDR_W(ADDR_W), .WORD_BYTES(6), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)
    ) dut (
        .Fg_CLK(clk), .RESET(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .done(done), .err(err), .table_valid(table_valid)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    logic [58:0] exp_q[$];
    logic [58:0] obs_q[$];
    int n_done = 0, n_err = 0, n_both = 0;

    // Observe outputs away from the active edge
    always @(negedge clk) begin
        if (wr_en) obs_q.push_back({wr_addr, wr_data});
        if (done) n_done++;
        if (err) n_err++;
        if (done && err) n_both++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clear_obs();
        obs_q.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    // Frame-level model: builds the byte stream and the list of RAM writes it must cause.
    task automatic prep_frame(input logic [10:0] addr, input int cnt, input bit bad, input bit fixed);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [11:0] c;
        logic [47:0] word;
        logic [7:0]  hdr[4];
        int          k;
        tx_q.delete();
        exp_q.delete();
        x = 8'h00;
        k = 0;
        c = 12'(cnt);
        hdr[0] = {5'b0, addr[10:8]};
        hdr[1] = addr[7:0];
        hdr[2] = {4'b0, c[11:8]};
        hdr[3] = c[7:0];
        tx_q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            tx_q.push_back(hdr[i]);
            x ^= hdr[i];
        end
        if (cnt >= 1 && cnt <= 2048) begin
            for (int w = 0; w < cnt; w++) begin
                word = '0;
                for (int j = 0; j < 6; j++) begin
                    k++;
                    b = fixed ? 8'(8'h11 * k) : 8'($urandom);
                    word = {word[39:0], b};
                    x ^= b;
                    tx_q.push_back(b);
                end
                exp_q.push_back({11'((int'(addr) + w) % 2048), word});
            end
            tx_q.push_back(bad ? (x ^ 8'h01) : x);
        end
    endtask

    task automatic compare_writes(input string name);
        check({name, "_nwr"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({name, "_wr"}, obs_q[i], exp_q[i]);
    endtask

    task automatic run_frame(input string name, input logic [10:0] addr, input int cnt,
                             input bit bad, input bit gaps,
                             input bit e_done, input bit e_err, input bit e_tv);
        prep_frame(addr, cnt, bad, 1'b0);
        clear_obs();
        foreach (tx_q[i]) begin
            if (gaps && ($urandom % 4 == 0)) idle($urandom_range(1, 3));
            send_byte(tx_q[i]);
        end
        idle(4);
        check({name, "_done"}, n_done, e_done);
        check({name, "_err"}, n_err, e_err);
        check({name, "_tv"}, table_valid, e_tv);
        check({name, "_busy"}, busy, 1'b0);
        compare_writes(name);
    endtask

    typedef struct {
        string       name;
        logic [10:0] addr;
        int          cnt;
        bit          bad;
        bit          e_done;
        bit          e_err;
        bit          e_tv;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int first_err;
        int wr_seen;
        int cnt;
        bit bad;
        bit legal;

        vecs[0] = '{"good",      11'h010, 2,     1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{"wrap",      11'h7FF, 2,     1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{"badchk",    11'h010, 2,     1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"cnt0",      11'h000, 0,     1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{"cnt801",    11'h000, 12'h801, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{"cntfff",    11'h000, 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{"cnt2048",   11'h005, 2048,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{"one",       11'h3FF, 1,     1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) tick();
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tv", table_valid, 1'b0);
        rst = 1'b0;
        tick();
        check("rst_outs", {wr_en, wr_addr, wr_data, busy, done, err, table_valid}, '0);

        // Test-plan frame with exact cycle timing, back-to-back bytes
        prep_frame(11'h010, 2, 1'b0, 1'b1);
        clear_obs();
        check("pre_busy", busy, 1'b0);
        foreach (tx_q[i]) begin
            send_byte(tx_q[i]);
            if (i == 0) check("sync_busy", busy, 1'b1);
            if (i == 9) check("w0_early", wr_en, 1'b0);
            if (i == 10) check("w0", {wr_en, wr_addr, wr_data}, {1'b1, 11'h010, 48'h112233445566});
            if (i == 16) check("w1", {wr_en, wr_addr, wr_data}, {1'b1, 11'h011, 48'h778899AABBCC});
            if (i == 17) check("chk_pulse", {done, err, table_valid, busy}, 4'b1011);
        end
        tick();
        check("post_pulse", {done, err, table_valid, busy}, 4'b0010);

        // Table-driven frames
        foreach (vecs[v])
            run_frame(vecs[v].name, vecs[v].addr, vecs[v].cnt, vecs[v].bad, 1'b0,
                      vecs[v].e_done, vecs[v].e_err, vecs[v].e_tv);

        // Illegal count: err exactly one cycle after CNT_L
        prep_frame(11'h000, 0, 1'b0, 1'b0);
        foreach (tx_q[i]) send_byte(tx_q[i]);
        check("cnt0_err_timing", {err, done, wr_en}, 3'b100);
        tick();
        check("cnt0_idle", {err, busy}, 2'b00);

        // Timeout after 3 data bytes
        prep_frame(11'h020, 1, 1'b0, 1'b0);
        clear_obs();
        for (int i = 0; i < 8; i++) send_byte(tx_q[i]);
        first_err = 0;
        wr_seen = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (err && first_err == 0) first_err = k;
            if (wr_en) wr_seen++;
        end
        check("tmo_cycle", first_err, TMO);
        check("tmo_no_wr", wr_seen, 0);
        check("tmo_busy", busy, 1'b0);
        run_frame("after_tmo", 11'h020, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Junk before SYNC is ignored
        clear_obs();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        idle(2);
        check("junk_err", n_err, 0);
        check("junk_busy", busy, 1'b0);
        run_frame("after_junk", 11'h040, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of DATA
        prep_frame(11'h100, 5, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) send_byte(tx_q[i]);
        rst = 1'b1;
        tick();
        check("midrst_outs", {wr_en, wr_addr, wr_data, busy, done, err, table_valid}, '0);
        rst = 1'b0;
        tick();
        run_frame("after_rst", 11'h100, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Randomized frames with occasional inter-byte gaps
        for (int r = 0; r < 40; r++) begin
            if ($urandom % 10 == 0)
                cnt = ($urandom % 2 == 1) ? 0 : int'($urandom_range(2049, 4095));
            else
                cnt = int'($urandom_range(1, 6));
            bad = ($urandom % 4 == 0);
            legal = (cnt >= 1 && cnt <= 2048);
            run_frame("rand", 11'($urandom), cnt, bad, 1'b1,
                      legal && !bad, !legal || bad, legal && !bad);
        end

        check("done_err_exclusive", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coef_ram_loader.md
Name: coef_ram_loader

Overview:
- Write-side counterpart of the coefficient lookup path: receives a framed byte stream and writes 48-bit coefficient words into the 2048-entry coefficient RAM.
- The RAM is read by the sin/cos2 lookup stage: {sin[23:0], cos2[23:0]} per address.
- Sits between the host byte link (UART/SPI deframer) and the RAM write port.
- Tells the lookup consumer when the table contents are valid.

Parameters:
- ADDR_W, 11, RAM address width; table depth is 2**ADDR_W.
- WORD_BYTES, 6, bytes per coefficient word (48 bits).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 65535, idle cycles allowed between bytes mid-frame before abort.

Ports:
- Fg_CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous reset, active-high.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid this cycle; a byte is accepted when rx_valid=1.
- wr_en  out  1  RAM write strobe, 1 cycle per word.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  48  RAM write data: [47:24] sin coef, [23:0] cos2 coef.
- busy  out  1  frame in progress (state != IDLE).
- done  out  1  1-cycle pulse: frame completed with good checksum.
- err  out  1  1-cycle pulse: frame aborted or checksum bad.
- table_valid  out  1  level: last frame loaded cleanly.

Behaviour:
- Reset: all outputs 0, state IDLE, wr_addr=0, checksum=0, timeout counter=0.
- Frame format (bytes in order):
  - SYNC_BYTE
  - ADDR_H: start address, bits [2:0] used
  - ADDR_L
  - CNT_H: word count, bits [3:0] used
  - CNT_L
  - count × 6 data bytes, MSB first
  - CHK
- States: IDLE → ADDR_H → ADDR_L → CNT_H → CNT_L → DATA → CHK → IDLE. Each transition advances on one accepted byte.
- IDLE:
  - Bytes other than SYNC_BYTE are ignored; no err.
  - On SYNC_BYTE: clear checksum, clear table_valid, go to ADDR_H.
- Checksum: XOR of every byte from ADDR_H through the last data byte. CHK must equal it.
- Count check, on CNT_L acceptance:
  - Legal range is 1..2048.
  - If count=0 or count>2048: err pulse next cycle, go to IDLE, no writes.
- DATA:
  - A byte counter 0..5 shifts bytes into a 48-bit assembly register.
  - On the 6th byte (cycle N), in cycle N+1: wr_en=1, wr_data=assembled word, wr_addr=current address.
  - The address then increments modulo 2**ADDR_W, so 2047 wraps to 0.
  - The remaining word count decrements. When it reaches 0, go to CHK.
- Writes are committed as they occur. A later checksum error does not roll them back; it leaves table_valid=0.
- CHK, byte accepted in cycle M:
  - If CHK matches: done=1 and table_valid=1 in cycle M+1.
  - Otherwise: err=1 in cycle M+1 and table_valid stays 0.
  - In both cases go to IDLE.
- Timeout:
  - The counter resets on every accepted byte and counts only while state != IDLE.
  - When it reaches TIMEOUT_CYC: err pulse, go to IDLE, discard any partial word (no wr_en).
- SYNC_BYTE appearing mid-frame is treated as ordinary data (no resync).
- done and err are never asserted in the same cycle.
- The final word's wr_en (cycle N+1) and the CHK byte arriving in cycle N+1 must both be handled. No bytes are dropped: rx has no backpressure and one byte per cycle is sustained.
- RESET mid-frame: immediate return to IDLE, all outputs 0 next cycle, table_valid=0.
- busy=1 from the cycle after SYNC acceptance until the cycle the done/err pulse is asserted (inclusive of the transition back to IDLE).

Test Plan:
- Good frame, back-to-back bytes: A5 00 10 00 02, data 11 22 33 44 55 66 / 77 88 99 AA BB CC, correct CHK.
  - wr_en at addr 0x010 with 0x112233445566, then at addr 0x011 with 0x778899AABBCC.
  - done pulse, table_valid=1.
- Wrap: start addr 0x7FF, count 2 → writes at 0x7FF then 0x000; done.
- Bad checksum on the good frame above (CHK xor 0x01).
  - Both writes occur.
  - err pulse, no done, table_valid=0.
- Count 0 (A5 00 00 00 00) and count 0x0801 → err after CNT_L, no wr_en, state IDLE.
- Timeout with TIMEOUT_CYC=16: stop after 3 data bytes → err at 16 idle cycles, no wr_en. A following valid frame loads correctly.
- Preamble and reset:
  - Junk bytes 00 FF 5A before SYNC are ignored with no err.
  - RESET asserted during DATA → outputs 0, the next frame loads cleanly.
